// File: rtl/isa_pkg.sv
// Shared ISA definitions: type encoding, opcode constants, field layout and the word packer.
package isa_pkg;

  // Field widths of the 32-bit instruction word.
  localparam int unsigned WordW   = 32;
  localparam int unsigned OpW     = 5;
  localparam int unsigned RegW    = 5;
  localparam int unsigned ShamtW  = 5;
  localparam int unsigned AluopW  = 5;
  localparam int unsigned ImmW    = 17;
  localparam int unsigned TargetW = 27;
  localparam int unsigned ErrW    = 8;

  // LSB position of each field inside the word; the decoder slices with the same numbers.
  localparam int unsigned OpLsb     = 27;
  localparam int unsigned RdLsb     = 22;
  localparam int unsigned RsLsb     = 17;
  localparam int unsigned RtLsb     = 12;
  localparam int unsigned ShamtLsb  = 7;
  localparam int unsigned AluopLsb  = 2;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned TargetLsb = 0;

  // Instruction type classes as carried on in_type.
  typedef enum logic [1:0] {
    TypeR   = 2'b00,
    TypeI   = 2'b01,
    TypeJi  = 2'b10,
    TypeJii = 2'b11
  } instr_type_e;

  // Opcode constants, grouped by the class they belong to.
  localparam logic [OpW-1:0] OpAlu  = 5'b00000;  // R class
  localparam logic [OpW-1:0] OpAddi = 5'b00101;  // I class
  localparam logic [OpW-1:0] OpI07  = 5'b00111;
  localparam logic [OpW-1:0] OpI08  = 5'b01000;
  localparam logic [OpW-1:0] OpI02  = 5'b00010;
  localparam logic [OpW-1:0] OpI06  = 5'b00110;
  localparam logic [OpW-1:0] OpJ01  = 5'b00001;  // JI class
  localparam logic [OpW-1:0] OpJ03  = 5'b00011;
  localparam logic [OpW-1:0] OpJ16  = 5'b10110;
  localparam logic [OpW-1:0] OpJ15  = 5'b10101;
  localparam logic [OpW-1:0] OpJr04 = 5'b00100;  // JII class

  // Encoder control states.
  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StFull = 1'b1
  } enc_state_e;

  // Field-level view of one incoming instruction.
  typedef struct packed {
    instr_type_e         ty;
    logic [OpW-1:0]      opcode;
    logic [RegW-1:0]     rd;
    logic [RegW-1:0]     rs;
    logic [RegW-1:0]     rt;
    logic [ShamtW-1:0]   shamt;
    logic [AluopW-1:0]   aluop;
    logic [ImmW-1:0]     imm;
    logic [TargetW-1:0]  target;
  } instr_fields_t;

  // Pack the fields of one instruction into its 32-bit word according to its type.
  function automatic logic [WordW-1:0] pack_word(instr_fields_t f);
    logic [WordW-1:0] w;
    w = '0;
    unique case (f.ty)
      TypeR:   w = {f.opcode, f.rd, f.rs, f.rt, f.shamt, f.aluop, 2'b00};
      TypeI:   w = {f.opcode, f.rd, f.rs, f.imm};
      TypeJi:  w = {f.opcode, f.target};
      TypeJii: w = {f.opcode, f.rd, 22'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_class_check.sv
// Combinational legality check: is this opcode a member of the declared type class?
module instr_class_check
  import isa_pkg::*;
(
  input  logic [1:0]     instr_type,
  input  logic [OpW-1:0] opcode,
  output logic           ok
);

  instr_type_e ty;
  assign ty = instr_type_e'(instr_type);

  // Each defined opcode belongs to exactly one class; undefined opcodes are never ok.
  always_comb begin
    ok = 1'b0;
    unique case (opcode)
      OpAlu:                               ok = (ty == TypeR);
      OpAddi, OpI07, OpI08, OpI02, OpI06:  ok = (ty == TypeI);
      OpJ01, OpJ03, OpJ16, OpJ15:          ok = (ty == TypeJi);
      OpJr04:                              ok = (ty == TypeJii);
      default:                             ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: checks, packs and addresses instructions for the imem write port.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_type,
  input  logic [OpW-1:0]      in_opcode,
  input  logic [RegW-1:0]     in_rd,
  input  logic [RegW-1:0]     in_rs,
  input  logic [RegW-1:0]     in_rt,
  input  logic [ShamtW-1:0]   in_shamt,
  input  logic [AluopW-1:0]   in_aluop,
  input  logic [ImmW-1:0]     in_imm,
  input  logic [TargetW-1:0]  in_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordW-1:0]    out_word,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                err_pulse,
  output logic [ErrW-1:0]     err_count,
  output logic                full
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  enc_state_e          state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                out_valid_q;
  logic [WordW-1:0]    out_word_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                err_pulse_q;
  logic [ErrW-1:0]     err_count_q;

  instr_fields_t       fields;
  logic [WordW-1:0]    packed_word;
  logic                class_ok;
  logic                handshake;
  logic                accept;
  logic                reject;

  // Gather the input fields and pack them into a word.
  always_comb begin
    fields        = '0;
    fields.ty     = instr_type_e'(in_type);
    fields.opcode = in_opcode;
    fields.rd     = in_rd;
    fields.rs     = in_rs;
    fields.rt     = in_rt;
    fields.shamt  = in_shamt;
    fields.aluop  = in_aluop;
    fields.imm    = in_imm;
    fields.target = in_target;
    packed_word   = pack_word(fields);
  end

  instr_class_check u_class_check (
    .instr_type (in_type),
    .opcode     (in_opcode),
    .ok         (class_ok)
  );

  // Ready only while running, the output slot is free or draining, and no restart is pending.
  assign in_ready  = (!out_valid_q || out_ready) && (state_q == StRun) && !clear && reset_n;
  assign handshake = in_valid && in_ready;
  assign accept    = handshake && class_ok;
  assign reject    = handshake && !class_ok;

  // Control FSM and address counter; clear restarts at address 0 and leaves FULL.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StRun;
      addr_q  <= '0;
    end else if (clear) begin
      state_q <= StRun;
      addr_q  <= '0;
    end else if (accept) begin
      if (addr_q == LastAddr) begin
        addr_q <= '0;
        if (!WRAP) begin
          state_q <= StFull;
        end
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Output register: load on accept, otherwise drop valid once the consumer takes the word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_word_q  <= packed_word;
      out_addr_q  <= addr_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Reject reporting: one-cycle pulse and a saturating count that survives clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= reject;
      if (reject && (err_count_q != '1)) begin
        err_count_q <= err_count_q + ErrW'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign full      = (state_q == StFull);

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder: the inverse of the processor's instruction decoder. Accepts field-level instructions (type, opcode, register fields, immediate, target) over a valid/ready handshake, checks the opcode against its declared type class, packs a 32-bit instruction word, and emits it with a sequential instruction-memory address. It sits in the program-loader path and feeds the imem write port.

## Interface
- DEPTH, 4096: imem words; addresses 0..DEPTH-1
- ADDR_W, 12: out_addr width, ≥ clog2(DEPTH)
- WRAP, 0: 1 = address wraps to 0 after DEPTH-1; 0 = stop in FULL
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- clear  in  1  restart: address 0, leave FULL
- in_valid / in_ready  in / out  1  input handshake
- in_type  in  2  00 R, 01 I, 10 JI, 11 JII
- in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop  in  5 each
- in_imm  in  17;  in_target  in  27
- out_valid / out_ready  out / in  1  output handshake
- out_word  out  32;  out_addr  out  ADDR_W
- err_pulse  out  1  one cycle per rejected instruction
- err_count  out  8  saturating count of rejects
- full  out  1  high in FULL state

## Operation
- Packing: R {op,rd,rs,rt,shamt,aluop,2'b00}; I {op,rd,rs,imm}; JI {op,target}; JII {op,rd,22'b0}.
- Class check: R iff op=00000; I iff op∈{00101,00111,01000,00010,00110}; JI iff op∈{00001,00011,10110,10101}; JII iff op=00100. Any mismatch (including undefined opcodes) is a reject.
- Reject: input consumed (handshake completes), no output word, address unchanged, err_pulse next cycle, err_count += 1 saturating at 255.
- Accept: word and current address loaded into the output register; address counter += 1.
- FSM: RUN, FULL. RUN→FULL when a valid word is accepted at address DEPTH-1 and WRAP=0. FULL→RUN only on clear. WRAP=1: DEPTH-1→0, FULL is never entered.
- in_ready = (!out_valid | out_ready) & state==RUN & !clear & reset_n.
- clear: address←0, state←RUN. A pending output word still drains unchanged. err_count is not cleared. clear together with in_valid: no acceptance.

## Timing
- Reset values: out_valid 0, out_word 0, out_addr 0, err_pulse 0, err_count 0, full 0, in_ready 0 during reset; state RUN, address 0.
- Latency 1: handshake in cycle N → out_valid and out_word/out_addr stable from N+1.
- Throughput 1 word/cycle with out_ready held high; back-to-back acceptance in the same cycle the output drains.
- out_valid high: out_word/out_addr held until out_valid & out_ready.
- err_pulse asserts exactly the cycle after a rejecting handshake.
- full rises the cycle after the DEPTH-1 acceptance; last word still drains.
- reset_n low mid-stream: pending output is discarded and all state returns to reset values on the next edge.

## Structure
- isa_pkg: opcode constants, type encoding (R/I/JI/JII), field widths and bit positions shared with the decoder.
- Sub-module instr_class_check: combinational opcode×type → ok.
- Top module: packing mux, output register, address counter, FSM, error counter.

## Test plan
- R: type 00, op 0, rd 1, rs 2, rt 3, shamt 0, aluop 0 → out_word 0x00443000, addr 0, one cycle later.
- I/JI/JII stream: addi rd1 rs0 imm5 → 0x28400005 @1; op 00001 target 0x100 → 0x08000100 @2; op 00100 rd 31 → 0x27C00000 @3; in_ready high every cycle.
- Reject: type 01 with op 00001 → no out_valid, err_pulse one cycle, err_count 1, next good word at the unchanged address.
- Backpressure: out_ready low 5 cycles → word held stable, in_ready low, no loss or duplication after release.
- DEPTH=4, WRAP=0: 4 words → full=1, in_ready 0; clear with in_valid high → not accepted, next word at addr 0. WRAP=1: fifth word at addr 0, full stays 0.
- Reset mid-stream with out_valid high → all outputs 0 next cycle; err_count 300 rejects → saturates at 255.
